spi_slave_rx: RTL and testbench

- SPI responder (slave) for the 24-bit, MSB-first, CS-framed stream produced by the team's SPI master/DAC driver.
- Oversamples SCK/CS/SDI in the system clock domain and assembles each frame.
- Presents each frame on a parallel port with a valid/ready handshake and flags framing and overrun errors.
- Shifts a response word out on MISO; used as an on-board DAC stand-in and as the loopback target for master verification.

---
 rtl/spi_slave_rx_if.sv | 12 +
 rtl/spi_slave_rx.sv | 150 +++++++++++++++
 tb/tb_spi_slave_rx.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_rx_if.sv
// Receive-side handshake bundle for spi_slave_rx: parallel frame plus valid/ready.
// The master modport belongs to the frame producer (the SPI responder).
interface spi_slave_rx_if #(
  parameter int FRAME_BITS = 24
);
  logic [FRAME_BITS-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/spi_slave_rx.sv
// SPI responder: oversamples SCK/CS/SDI, assembles CS-framed MSB-first words, shifts a reply on MISO.
// Optional SPI_SLAVE_ECHO_EN: MISO replays the last received frame instead of tx_data.
//
// state | meaning
// IDLE  | waiting for CS falling edge
// SHIFT | CS low: sample SDI on SCK rise, advance MISO on SCK fall
// DONE  | one cycle after CS rise: commit frame or flag framing error
module spi_slave_rx #(
  parameter int FRAME_BITS  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_sck,
  input  logic                  spi_cs,
  input  logic                  spi_sdi,
  output logic                  spi_miso,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic                  frame_err,
  output logic                  overrun,
  input  logic                  err_clr,
  spi_slave_rx_if.master        rx_bus
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] FULL = CW'(FRAME_BITS);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, sdi_sync;
  logic                   sck_hist, cs_hist;
  logic                   sck_s, cs_s, sdi_s;
  logic                   sck_rise, sck_fall, cs_rise, cs_fall;

  state_t                 state;
  logic [CW-1:0]          bit_cnt;
  logic                   bit_ovf;
  logic [FRAME_BITS-1:0]  rx_shift;
  logic [FRAME_BITS-2:0]  tx_shift;
  logic [FRAME_BITS-1:0]  tx_load;
  logic                   miso_q;
  logic [FRAME_BITS-1:0]  rx_data_q;
  logic                   rx_valid_q;
  logic                   frame_err_q;
  logic                   overrun_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_sync <= '0;
      cs_sync  <= '1;
      sdi_sync <= '0;
      sck_hist <= 1'b0;
      cs_hist  <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
      sck_hist <= sck_sync[SYNC_STAGES-1];
      cs_hist  <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_hist;
  assign sck_fall = ~sck_s & sck_hist;
  assign cs_rise  = cs_s & ~cs_hist;
  assign cs_fall  = ~cs_s & cs_hist;

`ifdef SPI_SLAVE_ECHO_EN
  logic unused_tx_data;
  assign unused_tx_data = ^tx_data;
  assign tx_load        = rx_data_q;
`else
  assign tx_load = tx_data;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      bit_ovf     <= 1'b0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      miso_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (rx_valid_q && rx_bus.rx_ready)
        rx_valid_q <= 1'b0;
      // Clears first so that a flag set later in this block wins.
      if (err_clr) begin
        frame_err_q <= 1'b0;
        overrun_q   <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (cs_fall) begin
            tx_shift <= tx_load[FRAME_BITS-2:0];
            miso_q   <= tx_load[FRAME_BITS-1];
            bit_cnt  <= '0;
            bit_ovf  <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state <= DONE;
          end else begin
            if (sck_rise) begin
              if (bit_cnt == FULL) begin
                bit_ovf <= 1'b1;
              end else begin
                rx_shift <= {rx_shift[FRAME_BITS-2:0], sdi_s};
                bit_cnt  <= bit_cnt + CW'(1);
              end
            end
            if (sck_fall) begin
              miso_q   <= tx_shift[FRAME_BITS-2];
              tx_shift <= {tx_shift[FRAME_BITS-3:0], 1'b0};
            end
          end
        end
        DONE: begin
          state <= IDLE;
          if (bit_cnt == FULL && !bit_ovf) begin
            rx_data_q  <= rx_shift;
            rx_valid_q <= 1'b1;
            // Newest frame wins; losing an unconsumed one is an overrun.
            if (rx_valid_q && !rx_bus.rx_ready)
              overrun_q <= 1'b1;
          end else begin
            frame_err_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign spi_miso        = miso_q;
  assign rx_bus.rx_data  = rx_data_q;
  assign rx_bus.rx_valid = rx_valid_q;
  assign frame_err       = frame_err_q;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: table-driven frames, scoreboard on the rx handshake.
// Build with +define+SPI_SLAVE_ECHO_EN to check the echo reply path instead of tx_data.
module tb_spi_slave_rx;

  logic        clk;
  logic        reset;
  logic        spi_sck, spi_cs, spi_sdi, spi_miso;
  logic [23:0] tx_data;
  logic        frame_err, overrun, err_clr;

  spi_slave_rx_if #(.FRAME_BITS(24)) rx_bus ();

  spi_slave_rx #(.FRAME_BITS(24), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .spi_sck   (spi_sck),
    .spi_cs    (spi_cs),
    .spi_sdi   (spi_sdi),
    .spi_miso  (spi_miso),
    .tx_data   (tx_data),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clr   (err_clr),
    .rx_bus    (rx_bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int hs_cnt = 0;
  logic sb_en = 1'b0;
  logic [23:0] sb_q[$];
`ifdef SPI_SLAVE_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  typedef struct {
    logic [23:0] data;
    int          nbits;
    logic        clr;
    logic [23:0] tx;
    logic [23:0] e_data;
    logic        e_valid;
    logic        e_ferr;
    logic        e_ovr;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Mode-0 master at SCK = clk/8; MISO sampled just before each rising edge.
  task automatic send_frame(input logic [23:0] d, input int nbits, output logic [23:0] miso_word);
    miso_word = '0;
    tick();
    spi_cs = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < nbits; i++) begin
      spi_sdi = (i < 24) ? d[23-i] : 1'b0;
      repeat (4) tick();
      if (i < 24) miso_word = {miso_word[22:0], spi_miso};
      spi_sck = 1'b1;
      repeat (4) tick();
      spi_sck = 1'b0;
    end
    repeat (4) tick();
    spi_cs = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sb_en && rx_bus.rx_valid && rx_bus.rx_ready) begin
      hs_cnt++;
      if (sb_q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected actual=%0h required=none", rx_bus.rx_data);
      end else begin
        chk("sb_data", {8'h0, rx_bus.rx_data}, {8'h0, sb_q.pop_front()});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] mw;
    logic [23:0] exp_rx;
    logic [23:0] exp_miso;

    vecs[0] = '{24'h000001, 24, 1'b0, 24'h111111, 24'h000001, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{24'hFFFFFE, 24, 1'b0, 24'hC0FFEE, 24'hFFFFFE, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{24'h000000,  0, 1'b1, 24'h000000, 24'hFFFFFE, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{24'h0ABCDE, 20, 1'b0, 24'h222222, 24'hFFFFFE, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{24'h000000,  0, 1'b1, 24'h000000, 24'hFFFFFE, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{24'h123456, 26, 1'b0, 24'h333333, 24'hFFFFFE, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{24'h000000,  0, 1'b1, 24'h000000, 24'hFFFFFE, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{24'h3C3C3C, 24, 1'b0, 24'h800001, 24'h3C3C3C, 1'b1, 1'b0, 1'b1};

    reset = 1'b0;
    spi_sck = 1'b0; spi_cs = 1'b1; spi_sdi = 1'b0;
    tx_data = '0; err_clr = 1'b0; rx_bus.rx_ready = 1'b0;
    exp_rx = '0;
    repeat (3) tick();
    chk("rst_rx_data", {8'h0, rx_bus.rx_data}, 32'h0);
    chk("rst_rx_valid", {31'h0, rx_bus.rx_valid}, 32'h0);
    chk("rst_frame_err", {31'h0, frame_err}, 32'h0);
    chk("rst_overrun", {31'h0, overrun}, 32'h0);
    chk("rst_miso", {31'h0, spi_miso}, 32'h0);
    reset = 1'b1;
    repeat (4) tick();

    // Single frame with exact latency from the CS rising pin edge.
    tx_data = 24'h123456;
    exp_miso = ECHO ? exp_rx : 24'h123456;
    send_frame(24'hA5C3F0, 24, mw);
    repeat (3) tick();
    chk("lat_early_valid", {31'h0, rx_bus.rx_valid}, 32'h0);
    tick();
    chk("lat_valid", {31'h0, rx_bus.rx_valid}, 32'h1);
    chk("single_data", {8'h0, rx_bus.rx_data}, 32'hA5C3F0);
    chk("single_ferr", {31'h0, frame_err}, 32'h0);
    chk("single_ovr", {31'h0, overrun}, 32'h0);
    chk("single_miso", {8'h0, mw}, {8'h0, exp_miso});
    exp_rx = 24'hA5C3F0;
    rx_bus.rx_ready = 1'b1;
    tick();
    rx_bus.rx_ready = 1'b0;
    chk("consume_valid", {31'h0, rx_bus.rx_valid}, 32'h0);

    foreach (vecs[i]) begin
      if (vecs[i].clr) begin
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
      end
      if (vecs[i].nbits > 0) begin
        tx_data = vecs[i].tx;
        exp_miso = ECHO ? exp_rx : vecs[i].tx;
        send_frame(vecs[i].data, vecs[i].nbits, mw);
        repeat (6) tick();
        if (vecs[i].nbits >= 24)
          chk($sformatf("v%0d_miso", i), {8'h0, mw}, {8'h0, exp_miso});
      end
      chk($sformatf("v%0d_data", i), {8'h0, rx_bus.rx_data}, {8'h0, vecs[i].e_data});
      chk($sformatf("v%0d_valid", i), {31'h0, rx_bus.rx_valid}, {31'h0, vecs[i].e_valid});
      chk($sformatf("v%0d_ferr", i), {31'h0, frame_err}, {31'h0, vecs[i].e_ferr});
      chk($sformatf("v%0d_ovr", i), {31'h0, overrun}, {31'h0, vecs[i].e_ovr});
      exp_rx = vecs[i].e_data;
    end

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_ovr", {31'h0, overrun}, 32'h0);

    // Handshake in the very DONE cycle: old frame consumed, new one kept, no overrun.
    sb_en = 1'b1;
    sb_q.push_back(24'h3C3C3C);
    send_frame(24'h5A5A5A, 24, mw);
    sb_q.push_back(24'h5A5A5A);
    repeat (3) tick();
    rx_bus.rx_ready = 1'b1;
    tick();
    rx_bus.rx_ready = 1'b0;
    chk("simul_valid", {31'h0, rx_bus.rx_valid}, 32'h1);
    chk("simul_data", {8'h0, rx_bus.rx_data}, 32'h5A5A5A);
    chk("simul_ovr", {31'h0, overrun}, 32'h0);

    rx_bus.rx_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic [23:0] d;
      d = 24'h010203 * (k + 5);
      send_frame(d, 24, mw);
      sb_q.push_back(d);
      repeat (2) tick();
    end
    repeat (8) tick();
    chk("sb_drained", sb_q.size(), 32'h0);
    chk("sb_hs_count", hs_cnt, 32'd5);
    chk("b2b_ovr", {31'h0, overrun}, 32'h0);
    chk("b2b_valid", {31'h0, rx_bus.rx_valid}, 32'h0);
    sb_en = 1'b0;
    rx_bus.rx_ready = 1'b0;

    // Reset mid-frame after 10 bits, then a clean frame.
    tick();
    spi_cs = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 10; i++) begin
      spi_sdi = i[0];
      repeat (4) tick();
      spi_sck = 1'b1;
      repeat (4) tick();
      spi_sck = 1'b0;
    end
    reset = 1'b0;
    #1;
    chk("midrst_data", {8'h0, rx_bus.rx_data}, 32'h0);
    chk("midrst_valid", {31'h0, rx_bus.rx_valid}, 32'h0);
    chk("midrst_miso", {31'h0, spi_miso}, 32'h0);
    spi_cs = 1'b1;
    spi_sck = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    repeat (4) tick();
    chk("postrst_ferr", {31'h0, frame_err}, 32'h0);
    tx_data = 24'hFEDCBA;
    exp_miso = ECHO ? 24'h000000 : 24'hFEDCBA;
    send_frame(24'h0F0F0F, 24, mw);
    repeat (6) tick();
    chk("postrst_data", {8'h0, rx_bus.rx_data}, 32'h0F0F0F);
    chk("postrst_valid", {31'h0, rx_bus.rx_valid}, 32'h1);
    chk("postrst_ferr2", {31'h0, frame_err}, 32'h0);
    chk("postrst_miso", {8'h0, mw}, {8'h0, exp_miso});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
